// File: rtl/trace_pkg.sv
// trace_pkg: shared encodings and entry layout for the writeback trace buffer
package trace_pkg;
  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_CAPTURE = 2'd1,
    STATE_DRAIN   = 2'd2,
    STATE_DONE    = 2'd3
  } state_t;
  localparam int MODE_STOP = 0;
  localparam int MODE_WRAP = 1;
  localparam int STAMP_LO = 0;
  function automatic int data_lo(input int stamp_w);
    return stamp_w;
  endfunction
  function automatic int addr_lo(input int stamp_w, input int data_w);
    return stamp_w + data_w;
  endfunction
  function automatic int entry_w(input int addr_w, input int data_w, input int stamp_w);
    return addr_w + data_w + stamp_w;
  endfunction
endpackage

// File: rtl/trace_ring_mem.sv
// trace_ring_mem: circular entry store with head/tail pointers, occupancy and combinational head read
module trace_ring_mem #(
  parameter int DEPTH = 16,
  parameter int W = 53
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     overwrite,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  always_ff @(posedge CLOCK)
    if (push) mem[tail] <= wdata;
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop || overwrite);
      tail  <= tail + PW'(push);
      count <= count + CW'(push && !overwrite) - CW'(pop);
    end
  assign rdata = mem[head];
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures filtered register-file writebacks into a ring and drains them over valid/ready
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int MODE    = 0
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     ARM,
  input  logic                     WB_EN,
  input  logic [ADDR_W-1:0]        WB_ADDR,
  input  logic [DATA_W-1:0]        WB_DATA,
  input  logic                     HALT,
  input  logic                     FILTER_EN,
  input  logic [ADDR_W-1:0]        FILTER_ADDR,
  output logic                     RD_VALID,
  input  logic                     RD_READY,
  output logic [ADDR_W-1:0]        RD_ADDR,
  output logic [DATA_W-1:0]        RD_DATA,
  output logic [STAMP_W-1:0]       RD_STAMP,
  output logic [1:0]               STATE,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int EW  = entry_w(ADDR_W, DATA_W, STAMP_W);
  localparam int DLO = data_lo(STAMP_W);
  localparam int ALO = addr_lo(STAMP_W, DATA_W);
  state_t state;
  logic [STAMP_W-1:0] stamp;
  logic [EW-1:0] wdata, rdata;
  logic [CW-1:0] count;
  logic qual, full, arm_ok, push, overwrite, pop, rd_valid;
  always_comb begin
    qual      = WB_EN && WB_ADDR != '0 && (!FILTER_EN || WB_ADDR == FILTER_ADDR);
    full      = count == CW'(DEPTH);
    arm_ok    = ARM && (state == STATE_IDLE || state == STATE_DONE);
    push      = state == STATE_CAPTURE && qual && (!full || MODE == MODE_WRAP);
    overwrite = push && full;
    rd_valid  = state == STATE_DRAIN && count != '0;
    pop       = rd_valid && RD_READY;
    wdata     = {WB_ADDR, WB_DATA, stamp};
  end
  trace_ring_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .clr       (arm_ok),
    .push      (push),
    .pop       (pop),
    .overwrite (overwrite),
    .wdata     (wdata),
    .rdata     (rdata),
    .count     (count)
  );
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      state    <= STATE_IDLE;
      stamp    <= '0;
      OVERFLOW <= 1'b0;
    end else
      case (state)
        STATE_IDLE, STATE_DONE:
          if (ARM) begin
            state    <= STATE_CAPTURE;
            stamp    <= '0;
            OVERFLOW <= 1'b0;
          end
        STATE_CAPTURE: begin
          stamp <= stamp + STAMP_W'(1);
          if (qual && full) OVERFLOW <= 1'b1;
          if (HALT) state <= STATE_DRAIN;
        end
        default:
          if (count == '0 || (pop && count == CW'(1))) state <= STATE_DONE;
      endcase
  assign RD_VALID = rd_valid;
  assign RD_ADDR  = rd_valid ? rdata[ALO +: ADDR_W] : '0;
  assign RD_DATA  = rd_valid ? rdata[DLO +: DATA_W] : '0;
  assign RD_STAMP = rd_valid ? rdata[STAMP_LO +: STAMP_W] : '0;
  assign STATE    = state;
  assign COUNT    = count;
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Hardware successor to the CPU bench's per-cycle register/writeback logging.
- Sits beside the pipeline's WB stage and captures register-file writes (address, data, cycle stamp) into a parametrised circular buffer.
- Capture filter, stop-or-wrap overflow policy, halt-triggered drain and a valid/ready readout, so the bench or a debug port reads the trace instead of scraping hierarchy.

Parameters:
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- DEPTH, 16, entries; power of two, >=2
- STAMP_W, 16, cycle-stamp width
- MODE, 0, 0 = STOP (drop new entries when full), 1 = WRAP (overwrite oldest)

Ports:
- CLOCK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- ARM  in  1  one-cycle start-capture request
- WB_EN  in  1  writeback enable (RegWriteEN_W)
- WB_ADDR  in  ADDR_W  writeback register (RegAddr3_W)
- WB_DATA  in  DATA_W  writeback data (RegWriteData_W)
- HALT  in  1  program-end indication; ends capture
- FILTER_EN  in  1  1 = capture only FILTER_ADDR
- FILTER_ADDR  in  ADDR_W  register to match when filtering
- RD_VALID  out  1  entry available at head
- RD_READY  in  1  consumer accepts head entry
- RD_ADDR  out  ADDR_W  head entry register
- RD_DATA  out  DATA_W  head entry data
- RD_STAMP  out  STAMP_W  head entry cycle stamp
- STATE  out  2  0 IDLE, 1 CAPTURE, 2 DRAIN, 3 DONE
- COUNT  out  $clog2(DEPTH)+1  occupied entries
- OVERFLOW  out  1  sticky: at least one event dropped or overwritten

Behaviour:
- Reset (RESET=0, async): STATE=IDLE; pointers, COUNT, cycle counter, OVERFLOW=0; RD_VALID=0; RD_ADDR/RD_DATA/RD_STAMP=0. Storage contents are don't-care.
- Qualifying event: WB_EN=1, WB_ADDR!=0, and (FILTER_EN=0 or WB_ADDR==FILTER_ADDR). $zero writes are never logged.
- IDLE:
  - Cycle counter held at 0.
  - ARM=1 moves to CAPTURE at the next edge and clears pointers, COUNT and OVERFLOW.
- CAPTURE:
  - Cycle counter increments every edge, wrapping modulo 2^STAMP_W. The first CAPTURE cycle has stamp 0.
  - A qualifying event is written at the tail with stamp = current counter value. COUNT increments at the same edge (1-cycle latency).
  - Full, MODE=0: event dropped, OVERFLOW<=1, COUNT stays DEPTH.
  - Full, MODE=1: oldest entry overwritten, head advances, COUNT stays DEPTH, OVERFLOW<=1.
  - HALT=1: a qualifying event in the same cycle is still captured; next state is DRAIN.
  - ARM is ignored.
- DRAIN:
  - RD_VALID = (COUNT!=0).
  - RD_* show the head entry combinationally and stay stable while RD_VALID=1 and RD_READY=0.
  - RD_VALID && RD_READY pops the head at the edge; COUNT decrements.
  - When COUNT becomes 0, next state is DONE.
  - Entering DRAIN with COUNT=0 goes to DONE on the following edge.
  - WB_EN and HALT are ignored; the cycle counter freezes.
- DONE:
  - RD_VALID=0; COUNT=0; OVERFLOW holds.
  - ARM=1 goes to CAPTURE with a full clear, as from IDLE.
- RD_VALID is never 1 outside DRAIN. RD_READY outside DRAIN has no effect.
- Pointers are $clog2(DEPTH) bits and wrap naturally. COUNT distinguishes full from empty.
- Reset asserted mid-capture or mid-drain discards all entries immediately.

Decomposition:
- Shared package trace_pkg holds:
  - STATE_IDLE, STATE_CAPTURE, STATE_DRAIN, STATE_DONE encodings
  - MODE_STOP, MODE_WRAP constants
  - Entry field offsets, entry width = ADDR_W+DATA_W+STAMP_W
- One sub-module, trace_ring_mem:
  - Parametrised DEPTH x entry-width register array with head/tail pointers and COUNT.
  - Inputs: push, pop, overwrite.
  - Combinational head read.
- The FSM, filter and stamp counter stay in wb_trace_buffer.

Test Plan (DEPTH=4, STAMP_W=16):
- Reset mid-CAPTURE with 3 entries held -> STATE=0, COUNT=0, RD_VALID=0, OVERFLOW=0 immediately (asynchronous, before the next edge).
- ARM; writes r8=5 at stamp 2, r9=-3 at stamp 4, r0=7 at stamp 5; HALT at stamp 6; RD_READY=1 -> reads (8,5,2) then (9,0xFFFFFFFD,4); r0 absent; DONE after 2 pops; OVERFLOW=0.
- MODE=0: 6 consecutive writes r1..r6 with data 10..15, then HALT -> COUNT=4; drain yields r1..r4; OVERFLOW=1.
- MODE=1: same stimulus -> drain yields r3..r6 (data 12..15, stamps 2..5); OVERFLOW=1.
- FILTER_EN=1, FILTER_ADDR=9: writes r8, r9, r10, r9 -> exactly 2 entries, both r9. HALT coinciding with a qualifying r9 write -> that entry is captured (3 total).
- Backpressure: in DRAIN, RD_READY held 0 for 5 cycles -> RD_* unchanged and COUNT unchanged. ARM in DRAIN -> ignored. HALT with COUNT=0 -> DONE one cycle after entering DRAIN, RD_VALID never 1.
